// File: rtl/riesgos_pkg.sv
// riesgos_pkg
// Shared definitions for the hazard/stall controller: the FSM state type,
// register-index width and the hard-wired zero register index.
package riesgos_pkg;

  localparam int REG_W = 5;

  // Register 0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } estado_t;

endpackage

// File: rtl/contador_saturado.sv
// contador_saturado
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    - clock
//   clear  - synchronous clear to zero (dominates enable)
//   enable - count up by one this cycle
//   count  - current value; sticks at all-ones instead of wrapping
module contador_saturado #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear wins; otherwise increment until all-ones, then hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/unidad_riesgos.sv
// unidad_riesgos
// Hazard/stall controller sitting beside the ID stage. Resolves what the
// forwarding unit cannot: load-use stalls, taken-branch flushes and a full
// pipeline freeze while data memory is busy. Also runs a watchdog on memory
// waits and a saturating count of stalled cycles.
// Ports:
//   clk, reset_n                     - clock, synchronous active-low reset
//   rs_id, rt_id, uses_rt_id         - source registers of the ID instruction
//   rt_ex, mem_read_ex               - destination / load flag of EX instruction
//   branch_taken_ex                  - branch resolved taken in EX
//   mem_access_mem, mem_ready        - MEM-stage access and its completion
//   pc_write, ifid_write             - PC and IF/ID enables
//   ifid_flush, idex_bubble          - squash IF/ID, inject NOP into ID/EX
//   freeze                           - hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout                      - sticky watchdog error
//   stall_count                      - saturating count of cycles with pc_write=0
module unidad_riesgos
  import riesgos_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rt_id,
  input  logic [REG_W-1:0] rt_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_access_mem,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

  estado_t     state;
  estado_t     nextState;
  logic        flushPend;
  logic        nextFlushPend;
  logic [15:0] waitCnt;
  logic [15:0] waitNext;
  logic        loadUse;
  logic        memWait;
  logic        branchEff;

  // Hazard conditions straight from the pipeline registers. A load into
  // register 0 is harmless, and Rt only matters if ID actually reads it.
  always_comb begin
    loadUse = mem_read_ex && (rt_ex != ZERO_REG) &&
              ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    memWait = mem_access_mem && !mem_ready;
  end

  // Next-state and control outputs. Freeze has top priority; when it is not
  // active a taken branch (live or remembered from before the freeze)
  // outranks load-use, since the flush discards the dependent instruction.
  always_comb begin
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    freeze        = 1'b0;
    nextState     = state;
    nextFlushPend = flushPend;
    branchEff     = 1'b0;

    if (!reset_n) begin
      pc_write      = 1'b0;
      ifid_write    = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
      nextState     = RUN;
      nextFlushPend = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (memWait) begin
            freeze        = 1'b1;
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            nextState     = MEM_WAIT;
            nextFlushPend = branch_taken_ex;
          end else begin
            branchEff = branch_taken_ex;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            freeze     = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
          end else begin
            branchEff     = flushPend || branch_taken_ex;
            nextState     = RUN;
            nextFlushPend = 1'b0;
          end
        end
        default: begin
          nextState     = RUN;
          nextFlushPend = 1'b0;
        end
      endcase

      if (!freeze) begin
        if (branchEff) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (loadUse) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
    end
  end

  // Watchdog count: zero whenever we are (going back) in RUN, counts each
  // cycle spent staying in MEM_WAIT, and parks at MAX_WAIT so it never wraps.
  always_comb begin
    waitNext = waitCnt;
    if (nextState == RUN) begin
      waitNext = '0;
    end else if ((state == MEM_WAIT) && (waitCnt != MAX_WAIT_C)) begin
      waitNext = waitCnt + 16'd1;
    end
  end

  // State register, pending flush, watchdog and its sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= RUN;
      flushPend   <= 1'b0;
      waitCnt     <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state     <= nextState;
      flushPend <= nextFlushPend;
      waitCnt   <= waitNext;
      if (waitNext == MAX_WAIT_C) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  contador_saturado #(
    .WIDTH (CNT_W)
  ) uStallCount (
    .clk    (clk),
    .clear  (!reset_n),
    .enable (!pc_write),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_unidad_riesgos.sv
// tb_unidad_riesgos
// Self-checking bench for unidad_riesgos: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and random stimulus compared against
// a cycle-level behavioural model.
module tb_unidad_riesgos;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       rs_id, rt_id, rt_ex;
  logic             uses_rt_id, mem_read_ex, branch_taken_ex;
  logic             mem_access_mem, mem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  unidad_riesgos #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .uses_rt_id      (uses_rt_id),
    .rt_ex           (rt_ex),
    .mem_read_ex     (mem_read_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_access_mem  (mem_access_mem),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .freeze          (freeze),
    .mem_timeout     (mem_timeout),
    .stall_count     (stall_count)
  );

  typedef struct packed {
    logic       rstN;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic [4:0] rtEx;
    logic       memRead;
    logic       branch;
    logic       memAccess;
    logic       memReady;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  pc;
    logic  ifid;
    logic  flush;
    logic  bubble;
    logic  frz;
  } vector_t;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state: are we waiting on memory, is a branch owed,
  // how many wait cycles so far, sticky timeout, stalled-cycle tally.
  bit modelValid = 1'b0;
  bit mInWait, mPend, mTimeout;
  int mWait, mStalls;

  logic obsPc, obsIfid, obsFlush, obsBubble, obsFreeze;
  logic expPc, expIfid, expFlush, expBubble, expFreeze;

  vector_t vecs [8];

  function automatic stim_t mk(input logic rstN, input logic [4:0] rs, input logic [4:0] rt,
                               input logic usesRt, input logic [4:0] rtEx, input logic memRead,
                               input logic branch, input logic memAccess, input logic memReady);
    stim_t s;
    s.rstN = rstN; s.rs = rs; s.rt = rt; s.usesRt = usesRt; s.rtEx = rtEx;
    s.memRead = memRead; s.branch = branch; s.memAccess = memAccess; s.memReady = memReady;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Expected control outputs for this cycle, from the hazard rules.
  task automatic modelOutputs(input stim_t s, output logic pc, output logic ifid,
                              output logic flush, output logic bubble, output logic frz);
    bit lu, hold, br;
    lu   = s.memRead && (s.rtEx != 0) && ((s.rtEx == s.rs) || (s.usesRt && (s.rtEx == s.rt)));
    hold = mInWait ? !s.memReady : (s.memAccess && !s.memReady);
    br   = s.branch || (mInWait && mPend);
    pc = 1'b1; ifid = 1'b1; flush = 1'b0; bubble = 1'b0; frz = 1'b0;
    if (!s.rstN) begin
      pc = 1'b0; ifid = 1'b0; flush = 1'b1; bubble = 1'b1;
    end else if (hold) begin
      frz = 1'b1; pc = 1'b0; ifid = 1'b0;
    end else if (br) begin
      flush = 1'b1; bubble = 1'b1;
    end else if (lu) begin
      pc = 1'b0; ifid = 1'b0; bubble = 1'b1;
    end
  endtask

  task automatic modelAdvance(input stim_t s, input logic pc);
    bit hold;
    if (!s.rstN) begin
      mInWait = 1'b0; mPend = 1'b0; mTimeout = 1'b0; mWait = 0; mStalls = 0;
      modelValid = 1'b1;
    end else begin
      if (!pc && (mStalls < CNT_MAX)) mStalls++;
      hold = mInWait ? !s.memReady : (s.memAccess && !s.memReady);
      if (hold) begin
        if (!mInWait) mPend = s.branch;
        else          mWait++;
        mInWait = 1'b1;
        if (mWait >= MAX_WAIT) mTimeout = 1'b1;
      end else begin
        mInWait = 1'b0; mPend = 1'b0; mWait = 0;
      end
    end
  endtask

  // One clock cycle: drive, let combinational outputs settle, compare with
  // the model, then cross the rising edge and step the model.
  task automatic applyStimulus(input stim_t s);
    reset_n = s.rstN; rs_id = s.rs; rt_id = s.rt; uses_rt_id = s.usesRt;
    rt_ex = s.rtEx; mem_read_ex = s.memRead; branch_taken_ex = s.branch;
    mem_access_mem = s.memAccess; mem_ready = s.memReady;
    #2;
    obsPc = pc_write; obsIfid = ifid_write; obsFlush = ifid_flush;
    obsBubble = idex_bubble; obsFreeze = freeze;
    modelOutputs(s, expPc, expIfid, expFlush, expBubble, expFreeze);
    checkOutput("pc_write", obsPc, expPc);
    checkOutput("ifid_write", obsIfid, expIfid);
    checkOutput("ifid_flush", obsFlush, expFlush);
    checkOutput("idex_bubble", obsBubble, expBubble);
    checkOutput("freeze", obsFreeze, expFreeze);
    if (modelValid) begin
      checkOutput("stall_count", stall_count, mStalls);
      checkOutput("mem_timeout", mem_timeout, mTimeout);
    end
    modelAdvance(s, expPc);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
  endtask

  initial begin
    stim_t s;

    // Single-cycle vectors starting from RUN: {inputs}, pc, ifid, flush, bubble, freeze
    vecs[0] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0};
    vecs[1] = '{mk(1, 5, 0, 0, 5, 1, 0, 0, 1), 0, 0, 0, 1, 0};
    vecs[2] = '{mk(1, 0, 0, 0, 0, 1, 0, 0, 1), 1, 1, 0, 0, 0};
    vecs[3] = '{mk(1, 3, 7, 0, 7, 1, 0, 0, 1), 1, 1, 0, 0, 0};
    vecs[4] = '{mk(1, 3, 7, 1, 7, 1, 0, 0, 1), 0, 0, 0, 1, 0};
    vecs[5] = '{mk(1, 5, 0, 0, 5, 1, 1, 0, 1), 1, 1, 1, 1, 0};
    vecs[6] = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 1), 1, 1, 0, 0, 0};
    vecs[7] = '{mk(1, 9, 9, 1, 9, 0, 0, 0, 1), 1, 1, 0, 0, 0};

    // Reset: forced outputs while held, cleared counters afterwards.
    doReset();
    checkOutput("rst_pc_write", obsPc, 0);
    checkOutput("rst_ifid_flush", obsFlush, 1);
    checkOutput("rst_idex_bubble", obsBubble, 1);
    doReset();
    checkOutput("rst_stall_count", stall_count, 0);
    checkOutput("rst_mem_timeout", mem_timeout, 0);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d_pc", i), obsPc, vecs[i].pc);
      checkOutput($sformatf("vec%0d_ifid", i), obsIfid, vecs[i].ifid);
      checkOutput($sformatf("vec%0d_flush", i), obsFlush, vecs[i].flush);
      checkOutput($sformatf("vec%0d_bubble", i), obsBubble, vecs[i].bubble);
      checkOutput($sformatf("vec%0d_freeze", i), obsFreeze, vecs[i].frz);
    end
    checkOutput("table_stall_count", stall_count, 2);

    // One load-use stall bumps the counter 0 -> 1, then the bubble clears it.
    doReset();
    applyStimulus(mk(1, 5, 0, 0, 5, 1, 0, 0, 1));
    checkOutput("lu_pc", obsPc, 0);
    checkOutput("lu_bubble", obsBubble, 1);
    checkOutput("lu_stall_count", stall_count, 1);
    applyStimulus(mk(1, 5, 0, 0, 0, 0, 0, 0, 1));
    checkOutput("lu_after_pc", obsPc, 1);

    // Three-cycle memory wait with a branch remembered from the first cycle.
    doReset();
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    checkOutput("mw_c1_freeze", obsFreeze, 1);
    checkOutput("mw_c1_flush", obsFlush, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
      checkOutput("mw_hold_freeze", obsFreeze, 1);
    end
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    checkOutput("mw_exit_freeze", obsFreeze, 0);
    checkOutput("mw_exit_flush", obsFlush, 1);
    checkOutput("mw_exit_pc", obsPc, 1);
    checkOutput("mw_stall_count", stall_count, 3);

    // MW + branch + LU together: freeze first, then the remembered branch wins.
    doReset();
    applyStimulus(mk(1, 5, 0, 0, 5, 1, 1, 1, 0));
    checkOutput("all3_freeze", obsFreeze, 1);
    checkOutput("all3_bubble", obsBubble, 0);
    applyStimulus(mk(1, 5, 0, 0, 5, 1, 0, 1, 1));
    checkOutput("all3_exit_flush", obsFlush, 1);
    checkOutput("all3_exit_pc", obsPc, 1);

    // MW + LU without a branch: load-use is re-evaluated on the exit cycle.
    doReset();
    applyStimulus(mk(1, 5, 0, 0, 5, 1, 0, 1, 0));
    applyStimulus(mk(1, 5, 0, 0, 5, 1, 0, 1, 1));
    checkOutput("mwlu_exit_pc", obsPc, 0);
    checkOutput("mwlu_exit_bubble", obsBubble, 1);
    checkOutput("mwlu_exit_freeze", obsFreeze, 0);

    // Watchdog: sets after MAX_WAIT cycles in MEM_WAIT and stays set.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    checkOutput("wd_before", mem_timeout, 0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("wd_set", mem_timeout, 1);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("wd_sticky", mem_timeout, 1);
    // Reset mid-wait: back in RUN, pending branch dropped.
    doReset();
    checkOutput("wd_rst_timeout", mem_timeout, 0);
    checkOutput("wd_rst_stall", stall_count, 0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("wd_rst_run_freeze", obsFreeze, 0);
    checkOutput("wd_rst_no_flush", obsFlush, 0);

    // Stall counter saturation at 15 for a 4-bit counter.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    checkOutput("sat_stall_count", stall_count, 15);

    // Random traffic against the model; small register range to provoke matches.
    doReset();
    for (int i = 0; i < 500; i++) begin
      s = mk(($urandom_range(0, 49) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      applyStimulus(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/unidad_riesgos.md
# unidad_riesgos

Hazard/stall controller for the 5-stage pipeline, the counterpart to the EX-stage forwarding unit: it handles the cases forwarding cannot resolve. It stalls on load-use, flushes on taken branches, and freezes the whole pipeline while data memory is not ready. It sits beside the ID stage and drives the PC, IF/ID and ID/EX write/bubble controls. It also keeps a watchdog on memory waits and a stall performance counter.

## Interface
Parameters:
- MAX_WAIT, 255: memory-wait cycles before `mem_timeout` sets (1..65535).
- CNT_W, 16: width of `stall_count`.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  synchronous, active-low reset
- rs_id  in  5  Rs of the instruction in ID
- rt_id  in  5  Rt of the instruction in ID
- uses_rt_id  in  1  ID instruction reads Rt (R-type, store, beq)
- rt_ex  in  5  destination register of the instruction in EX
- mem_read_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  branch resolved taken in EX
- mem_access_mem  in  1  MEM instruction is a load or store
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP control into ID/EX
- freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0

## Operation
- Load-use condition: `LU` = `mem_read_ex` && `rt_ex`≠0 && (`rt_ex`==`rs_id` || (`uses_rt_id` && `rt_ex`==`rt_id`)).
- Memory-wait condition: `MW` = `mem_access_mem` && !`mem_ready`.
- States: RUN, MEM_WAIT. Internal flag `flush_pend`.
- Default outputs: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0, `freeze`=0.
- RUN priority, highest first:
  - MW: `freeze`=1, `pc_write`=0, `ifid_write`=0. Next state MEM_WAIT. `flush_pend` is set to `branch_taken_ex`.
  - `branch_taken_ex`: `ifid_flush`=1, `idex_bubble`=1. `pc_write`=1 loads the target.
  - LU: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Exactly one stall cycle per load, because the bubble clears LU next cycle.
- MEM_WAIT:
  - While !`mem_ready`: `freeze`=1, `pc_write`=0, `ifid_write`=0.
  - On `mem_ready`=1: `freeze`=0. Apply the RUN rules for branch/LU, treating (`flush_pend` || `branch_taken_ex`) as the branch. Next state RUN; clear `flush_pend`.
- Watchdog: `wait_cnt` increments each cycle in MEM_WAIT and resets to 0 on entering RUN.
  - When `wait_cnt` reaches MAX_WAIT, `mem_timeout` is set.
  - `mem_timeout` stays set until reset. The FSM remains in MEM_WAIT.
- `stall_count`: +1 on each cycle with `pc_write`=0 (freeze or LU). Saturates at all-ones.

## Timing
- All control outputs are combinational from inputs and state, with zero-cycle latency.
- State, `flush_pend`, `wait_cnt`, `mem_timeout` and `stall_count` update on the rising edge of `clk`.
- While `reset_n`=0 the outputs are forced to: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1, `freeze`=0.
- Reset values: state RUN, `flush_pend`=0, `wait_cnt`=0, `mem_timeout`=0, `stall_count`=0.
- Reset mid-wait: RUN after the next edge; the pending flush is discarded.
- `mem_ready`=1 in the first cycle of an access means MW=0: no freeze and no state change.
- Simultaneous MW, branch and LU: freeze wins, the branch is remembered, and LU is re-evaluated on exit.
- `rt_ex`=0: never a load-use stall.

## Structure
- Package `riesgos_pkg`: state enum (RUN=0, MEM_WAIT=1), REG_W=5, zero-register constant.
- Sub-module `contador_saturado` (parameter width; enable/clear) is used for `stall_count`; `wait_cnt` uses inline logic.

## Test plan
- `mem_read_ex`=1, `rt_ex`=5, `rs_id`=5 → one cycle with `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; `stall_count` 0→1.
- LU with `rt_ex`=0, `rs_id`=0 → no stall. `rt_ex`=7, `rt_id`=7, `uses_rt_id`=0 → no stall.
- `branch_taken_ex`=1 together with LU true → `ifid_flush`=1, `idex_bubble`=1, `pc_write`=1.
- `mem_access_mem`=1, `mem_ready` low for 3 cycles, `branch_taken_ex`=1 in the first cycle only → `freeze`=1 for 3 cycles; on the `mem_ready` cycle `ifid_flush`=1; `stall_count`=3.
- MAX_WAIT=4, `mem_ready` held low → `mem_timeout` rises when `wait_cnt` hits 4 and stays high. Then `reset_n`=0 for one edge → `mem_timeout`=0, state RUN, `stall_count`=0.
- CNT_W=4 with 20 consecutive stall cycles → `stall_count` holds 15.
